// File: rtl/switch_interface.sv
// Memory-mapped switch bank peripheral: level, sticky edge flags, interrupt mask
// and a level interrupt to the core.
module switch_interface #(
   parameter int N_SW = 16
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic [N_SW-1:0] sw_db_i,
   input  logic            sel_i,
   input  logic            we_i,
   input  logic [1:0]      addr_i,
   input  logic [31:0]     wdata_i,
   output logic [31:0]     rdata_o,
   output logic            irq_o
);

   localparam logic [1:0] ADDR_STATE = 2'd0;
   localparam logic [1:0] ADDR_RISE  = 2'd1;
   localparam logic [1:0] ADDR_FALL  = 2'd2;
   localparam logic [1:0] ADDR_MASK  = 2'd3;

   logic            r_init;
   logic [N_SW-1:0] r_sw_prev;
   logic [N_SW-1:0] r_rise;
   logic [N_SW-1:0] r_fall;
   logic [N_SW-1:0] r_mask;

   logic            w_wr;
   logic            w_rd;
   logic [N_SW-1:0] w_rise_evt;
   logic [N_SW-1:0] w_fall_evt;
   logic [N_SW-1:0] w_rise_clr;
   logic [N_SW-1:0] w_fall_clr;
   logic [N_SW-1:0] w_rise_next;
   logic [N_SW-1:0] w_fall_next;
   logic [N_SW-1:0] w_mask_next;
   logic            w_irq_next;
   logic [31:0]     w_rd_val;

   assign w_wr = sel_i & we_i;
   assign w_rd = sel_i & ~we_i;

   // The first cycle after reset only captures the level, so switches already
   // high at reset never look like rising edges.
   assign w_rise_evt = r_init ? '0 : (sw_db_i & ~r_sw_prev);
   assign w_fall_evt = r_init ? '0 : (~sw_db_i & r_sw_prev);

   assign w_rise_clr = (w_wr && addr_i == ADDR_RISE) ? wdata_i[N_SW-1:0] : '0;
   assign w_fall_clr = (w_wr && addr_i == ADDR_FALL) ? wdata_i[N_SW-1:0] : '0;

   // New events are OR-ed in after the clear, so a set wins over a W1C.
   assign w_rise_next = (r_rise & ~w_rise_clr) | w_rise_evt;
   assign w_fall_next = (r_fall & ~w_fall_clr) | w_fall_evt;
   assign w_mask_next = (w_wr && addr_i == ADDR_MASK) ? wdata_i[N_SW-1:0] : r_mask;
   assign w_irq_next  = |((w_rise_next | w_fall_next) & w_mask_next);

   // NOTE: every signal written in always_comb gets a default first, otherwise
   // an unassigned path infers a latch.
   always_comb begin
      w_rd_val = '0;
      unique case (addr_i)
         ADDR_STATE: w_rd_val[N_SW-1:0] = r_sw_prev;
         ADDR_RISE:  w_rd_val[N_SW-1:0] = r_rise;
         ADDR_FALL:  w_rd_val[N_SW-1:0] = r_fall;
         ADDR_MASK:  w_rd_val[N_SW-1:0] = r_mask;
         default:    w_rd_val = '0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of the others.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_init    <= 1'b1;
         r_sw_prev <= '0;
         r_rise    <= '0;
         r_fall    <= '0;
         r_mask    <= '0;
         rdata_o   <= '0;
         irq_o     <= 1'b0;
      end else begin
         r_init    <= 1'b0;
         r_sw_prev <= sw_db_i;
         r_rise    <= w_rise_next;
         r_fall    <= w_fall_next;
         r_mask    <= w_mask_next;
         irq_o     <= w_irq_next;
         if (w_rd) begin
            rdata_o <= w_rd_val;
         end
      end
   end

endmodule

// File: tb/tb_switch_interface.sv
// Randomised and directed checks of switch_interface against a bit-level
// behavioural model of the register set.
module tb_switch_interface;

   localparam int N = 16;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic [N-1:0]  sw_db_i;
   logic          sel_i;
   logic          we_i;
   logic [1:0]    addr_i;
   logic [31:0]   wdata_i;
   logic [31:0]   rdata_o;
   logic          irq_o;

   int total = 0;
   int bad   = 0;

   logic [N-1:0]  cur_sw;

   // model state
   logic          m_init;
   logic [N-1:0]  m_prev, m_rise, m_fall, m_mask;
   logic [31:0]   m_rdata;
   logic          m_irq;

   switch_interface #(.N_SW(N)) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .sw_db_i (sw_db_i),
      .sel_i   (sel_i),
      .we_i    (we_i),
      .addr_i  (addr_i),
      .wdata_i (wdata_i),
      .rdata_o (rdata_o),
      .irq_o   (irq_o)
   );

   always #50 clk_i = ~clk_i;

   task automatic model_reset();
      m_init  = 1'b1;
      m_prev  = '0;
      m_rise  = '0;
      m_fall  = '0;
      m_mask  = '0;
      m_rdata = '0;
      m_irq   = 1'b0;
   endtask

   function automatic logic [31:0] model_reg(input logic [1:0] a);
      logic [31:0] v;
      v = 32'd0;
      if (a == 2'd0) v[N-1:0] = m_prev;
      if (a == 2'd1) v[N-1:0] = m_rise;
      if (a == 2'd2) v[N-1:0] = m_fall;
      if (a == 2'd3) v[N-1:0] = m_mask;
      return v;
   endfunction

   // One clock: drive at the falling edge, advance the model at the rising edge.
   task automatic cycle(input logic [N-1:0] sw, input logic sel, input logic we,
                        input logic [1:0] a, input logic [31:0] wd);
      int any;
      @(negedge clk_i);
      sw_db_i = sw; sel_i = sel; we_i = we; addr_i = a; wdata_i = wd;
      @(posedge clk_i);
      if (sel && !we) m_rdata = model_reg(a);
      for (int i = 0; i < N; i++) begin
         if (sel && we && a == 2'd1 && wd[i]) m_rise[i] = 1'b0;
         if (sel && we && a == 2'd2 && wd[i]) m_fall[i] = 1'b0;
         if (!m_init && sw[i] && !m_prev[i]) m_rise[i] = 1'b1;
         if (!m_init && !sw[i] && m_prev[i]) m_fall[i] = 1'b1;
      end
      if (sel && we && a == 2'd3) m_mask = wd[N-1:0];
      m_prev = sw;
      m_init = 1'b0;
      any = 0;
      for (int i = 0; i < N; i++)
         if ((m_rise[i] || m_fall[i]) && m_mask[i]) any = 1;
      m_irq = (any != 0);
      #1;
   endtask

   task automatic idle();              cycle(cur_sw, 1'b0, 1'b0, 2'd0, 32'd0); endtask
   task automatic rd(input logic [1:0] a); cycle(cur_sw, 1'b1, 1'b0, a, 32'd0); endtask
   task automatic wr(input logic [1:0] a, input logic [31:0] d); cycle(cur_sw, 1'b1, 1'b1, a, d); endtask

   task automatic test_reset();
      cur_sw  = 16'h00F0;
      sw_db_i = cur_sw; sel_i = 0; we_i = 0; addr_i = 0; wdata_i = 0;
      reset_i = 1'b0;
      model_reset();
      #230;
      total++;
      if (rdata_o !== 32'd0 || irq_o !== 1'b0) begin
         bad++; $display("FAIL reset_state: rdata=%h irq=%b want 0/0", rdata_o, irq_o);
      end
      reset_i = 1'b1;
      idle();
      rd(2'd1);
      total++;
      if (rdata_o !== 32'd0 || irq_o !== 1'b0) begin
         bad++; $display("FAIL reset_rise: rdata=%h irq=%b want 0/0", rdata_o, irq_o);
      end
      rd(2'd0);
      total++;
      if (rdata_o !== 32'h000000F0) begin
         bad++; $display("FAIL reset_state_read: rdata=%h want 000000f0", rdata_o);
      end
      rd(2'd2);
      total++;
      if (rdata_o !== 32'd0) begin
         bad++; $display("FAIL reset_fall: rdata=%h want 0", rdata_o);
      end
   endtask

   task automatic test_rise_irq();
      wr(2'd3, 32'h1);
      cur_sw = cur_sw | 16'h0001;
      idle();
      total++;
      if (irq_o !== 1'b1) begin
         bad++; $display("FAIL rise_irq: irq=%b want 1", irq_o);
      end
      rd(2'd1);
      total++;
      if (rdata_o !== 32'h1) begin
         bad++; $display("FAIL rise_flag: rdata=%h want 00000001", rdata_o);
      end
      wr(2'd1, 32'h1);
      total++;
      if (irq_o !== 1'b0) begin
         bad++; $display("FAIL rise_clear_irq: irq=%b want 0", irq_o);
      end
      rd(2'd1);
      total++;
      if (rdata_o !== 32'h0) begin
         bad++; $display("FAIL rise_cleared: rdata=%h want 0", rdata_o);
      end
   endtask

   task automatic test_fall_mask();
      wr(2'd3, 32'h0);
      cur_sw = cur_sw & ~16'h0020;
      idle();
      rd(2'd2);
      total++;
      if (rdata_o !== 32'h20 || irq_o !== 1'b0) begin
         bad++; $display("FAIL fall_flag: rdata=%h irq=%b want 00000020/0", rdata_o, irq_o);
      end
      wr(2'd3, 32'h20);
      total++;
      if (irq_o !== 1'b1) begin
         bad++; $display("FAIL fall_mask_irq: irq=%b want 1", irq_o);
      end
      wr(2'd2, 32'h20);
      total++;
      if (irq_o !== 1'b0) begin
         bad++; $display("FAIL fall_clear_irq: irq=%b want 0", irq_o);
      end
   endtask

   task automatic test_set_clear();
      wr(2'd3, 32'h8);
      cur_sw = cur_sw & ~16'h0008;
      idle();
      wr(2'd2, 32'hFFFF);
      cur_sw = cur_sw | 16'h0008;
      idle();
      cur_sw = cur_sw & ~16'h0008;
      idle();
      cur_sw = cur_sw | 16'h0008;
      wr(2'd1, 32'h8);             // clear coincides with a new rising edge
      total++;
      if (irq_o !== 1'b1) begin
         bad++; $display("FAIL set_wins_irq: irq=%b want 1", irq_o);
      end
      rd(2'd1);
      total++;
      if (rdata_o[3] !== 1'b1 || rdata_o !== m_rdata) begin
         bad++; $display("FAIL set_wins_flag: rdata=%h want %h (bit3 set)", rdata_o, m_rdata);
      end
      wr(2'd1, 32'hFFFF);
      wr(2'd2, 32'hFFFF);
   endtask

   task automatic test_ro_and_b2b();
      wr(2'd0, 32'hFFFFFFFF);
      wr(2'd3, 32'hFFFFFFFF);
      rd(2'd3);
      total++;
      if (rdata_o !== 32'h0000FFFF) begin
         bad++; $display("FAIL mask_width: rdata=%h want 0000ffff", rdata_o);
      end
      rd(2'd0);
      total++;
      if (rdata_o !== {16'd0, cur_sw}) begin
         bad++; $display("FAIL state_ro: rdata=%h want %h", rdata_o, {16'd0, cur_sw});
      end
      cur_sw = 16'hA5C3;
      for (int a = 0; a < 4; a++) begin
         rd(a[1:0]);
         total++;
         if (rdata_o !== m_rdata || irq_o !== m_irq) begin
            bad++; $display("FAIL b2b_read[%0d]: rdata=%h irq=%b want %h/%b", a, rdata_o, irq_o, m_rdata, m_irq);
         end
      end
   endtask

   task automatic test_random();
      logic [1:0]  a;
      logic [31:0] wd;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) cur_sw = cur_sw ^ (16'(1) << $urandom_range(0, N - 1));
         a  = 2'($urandom_range(0, 3));
         wd = ($urandom_range(0, 1) == 1) ? $urandom : (32'(1) << $urandom_range(0, 31));
         cycle(cur_sw, ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0), a, wd);
         total++;
         if (rdata_o !== m_rdata || irq_o !== m_irq) begin
            bad++; $display("FAIL random[%0d]: rdata=%h irq=%b want %h/%b", c, rdata_o, irq_o, m_rdata, m_irq);
         end
      end
   endtask

   task automatic test_async_reset();
      wr(2'd3, 32'hFFFF);
      cur_sw = cur_sw ^ 16'h0100;
      idle();
      rd(2'd3);
      total++;
      if (irq_o !== 1'b1 || rdata_o !== 32'h0000FFFF) begin
         bad++; $display("FAIL pre_reset: rdata=%h irq=%b want 0000ffff/1", rdata_o, irq_o);
      end
      #20;
      reset_i = 1'b0;
      model_reset();
      #1;
      total++;
      if (irq_o !== 1'b0 || rdata_o !== 32'd0) begin
         bad++; $display("FAIL async_reset: rdata=%h irq=%b want 0/0", rdata_o, irq_o);
      end
      cur_sw = 16'h8001;
      #100;
      reset_i = 1'b1;
      idle();
      idle();
      rd(2'd1);
      total++;
      if (rdata_o !== 32'd0 || irq_o !== 1'b0) begin
         bad++; $display("FAIL post_reset_rise: rdata=%h irq=%b want 0/0", rdata_o, irq_o);
      end
      rd(2'd0);
      total++;
      if (rdata_o !== 32'h00008001) begin
         bad++; $display("FAIL post_reset_state: rdata=%h want 00008001", rdata_o);
      end
   endtask

   initial begin
      test_reset();
      test_rise_irq();
      test_fall_mask();
      test_set_clear();
      test_ro_and_b2b();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/switch_interface.md
Name: switch_interface

Overview:
- Bus-side peripheral for the switch bank.
- Consumes the N debounced, clk-synchronous switch levels produced by the per-switch debounce stage.
- Presents them to the RISC-V core as a small memory-mapped register set: current state, sticky rising-edge flags, sticky falling-edge flags and an interrupt mask.
- Drives one level interrupt line to the core.

Parameters:
- N_SW, 16: number of debounced switch inputs; 1..32.

Ports:
- clk_i  input  1  system clock, 10 MHz
- reset_i  input  1  asynchronous active-low reset
- sw_db_i  input  N_SW  debounced switch levels, one bit per switch, synchronous to clk_i
- sel_i  input  1  bus select for this peripheral, one-cycle strobe per access
- we_i  input  1  1 = write, 0 = read; meaningful only when sel_i=1
- addr_i  input  2  word register offset
- wdata_i  input  32  write data
- rdata_o  output  32  read data, registered
- irq_o  output  1  interrupt request, registered level

Behaviour:
- Reset, asynchronous on reset_i=0:
  - sw_prev, RISE, FALL, MASK and rdata_o are 0; irq_o=0.
  - init flag is set.
- First clock after reset release (init set):
  - sw_prev <= sw_db_i; init cleared.
  - No edge flags are set, so switches already high at reset do not produce spurious rising events.
- Edge detect, every later cycle:
  - rise = sw_db_i & ~sw_prev; fall = ~sw_db_i & sw_prev.
  - sw_prev <= sw_db_i.
  - RISE |= rise; FALL |= fall. Flags are sticky.
- Register map (addr_i):
  - 0 STATE, RO: bits [N_SW-1:0] = sw_prev, i.e. the registered level, one cycle behind sw_db_i. Writes are ignored.
  - 1 RISE, W1C: a write clears the bits set in wdata_i[N_SW-1:0].
  - 2 FALL, W1C: same clear rule as RISE.
  - 3 MASK, RW: a write loads wdata_i[N_SW-1:0].
  - Bits [31:N_SW] always read 0.
- Read timing:
  - When sel_i=1 and we_i=0 at edge k, rdata_o holds the addressed register value as it stood before edge k, valid from edge k until the next read.
  - Read latency is one cycle.
  - rdata_o holds its value when no read occurs.
- Write timing: takes effect at the sampling edge. Back-to-back accesses are allowed every cycle, with no wait states.
- Simultaneous set and clear: if a W1C clear of bit i coincides with a new edge on bit i in the same cycle, the set wins and the flag stays 1, so no event is lost.
- Interrupt:
  - irq_o <= |((RISE_next | FALL_next) & MASK_next), computed from the values being written at this edge.
  - irq_o therefore rises one cycle after the edge is visible on sw_db_i, and falls one cycle after the clearing write or mask write.
- Reading never alters flags; reads have no side effects.
- Reset asserted mid-operation clears everything immediately, independent of clk_i. After release, the init rule above applies again.
- No state machine beyond the init flag. Implementation is registers plus edge logic plus read mux.

Test Plan:
- Reset release with sw_db_i=16'h00F0 held, then read RISE and STATE -> RISE=0, FALL=0, irq_o=0; STATE=32'h000000F0 two cycles after release.
- MASK=16'h0001, sw_db_i bit0 0->1 at cycle t -> RISE bit0=1 at t+1, irq_o=1 at t+1. Write RISE with 32'h1 -> irq_o=0 one cycle later; RISE reads 0.
- MASK=0, toggle bit5 1->0 -> FALL=32'h20, irq_o stays 0. Then write MASK=32'h20 -> irq_o=1 the following cycle.
- W1C of RISE bit3 in the same cycle as a new rising edge on bit3 -> RISE bit3 remains 1 and irq stays asserted if masked.
- Write 32'hFFFFFFFF to STATE and to MASK, then read MASK and STATE -> MASK reads 32'h0000FFFF; STATE is unchanged and reflects sw_db_i. Back-to-back reads of addr 0,1,2,3 return the correct values on consecutive cycles.
- Assert reset_i=0 asynchronously between edges with flags and MASK set -> irq_o and rdata_o drop to 0 immediately; after release, a held-high switch produces no RISE flag.
